// File: rtl/seq_pkg.sv
// Shared encodings for the state sequencer: traversal modes and ping-pong direction.
package seq_pkg;

  localparam logic [1:0] MODE_LOOP_UP = 2'b00;
  localparam logic [1:0] MODE_LOOP_DN = 2'b01;
  localparam logic [1:0] MODE_PING    = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/dwell_timer.sv
// Per-state dwell counter; expires when the count reaches the live iDwell value.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iClear,
  input  logic               iEnable,
  input  logic [DWELL_W-1:0] iDwell,
  output logic               oExpire
);

  logic [DWELL_W-1:0] countR;

  assign oExpire = (countR == iDwell) && iEnable;

  // Counter: clear wins, expiry restarts the dwell, a lowered iDwell just lets it wrap.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      countR <= DWELL_W'(0);
    end else if (iClear) begin
      countR <= DWELL_W'(0);
    end else if (oExpire) begin
      countR <= DWELL_W'(0);
    end else if (iEnable) begin
      countR <= countR + DWELL_W'(1);
    end else begin
      countR <= countR;
    end
  end

endmodule

// File: rtl/state_sequencer.sv
// Parametrised state sequencer with programmable dwell and four traversal modes.
module state_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STATES = 3,
  parameter int STATE_W    = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
  parameter int DWELL_W    = 8
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iRestart,
  input  logic                  iPause,
  input  logic [1:0]            iMode,
  input  logic [DWELL_W-1:0]    iDwell,
  output logic [STATE_W-1:0]    oValorEstado,
  output logic [NUM_STATES-1:0] oOneHot,
  output logic                  oWrap,
  output logic                  oDone
);

  localparam logic [STATE_W-1:0]    LAST     = STATE_W'(NUM_STATES - 1);
  localparam logic [NUM_STATES-1:0] ONE_HOT0 = NUM_STATES'(1);

  logic                  expire;
  logic                  dirR;
  logic                  dirNxt;
  logic                  doneNxt;
  logic                  wrapNxt;
  logic [STATE_W-1:0]    stateNxt;
  logic [NUM_STATES-1:0] oneHotNxt;

  // Once one-shot is done the counter stops so no further expiry can occur.
  dwell_timer #(.DWELL_W(DWELL_W)) uTimer (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iClear  (iRestart),
    .iEnable (!iPause && !oDone),
    .iDwell  (iDwell),
    .oExpire (expire)
  );

  // Next-state, direction, done and wrap decisions.
  always_comb begin
    stateNxt = oValorEstado;
    dirNxt   = dirR;
    doneNxt  = oDone;
    wrapNxt  = 1'b0;
    if (iRestart) begin
      stateNxt = STATE_W'(0);
      dirNxt   = DIR_UP;
      doneNxt  = 1'b0;
    end else if (iPause) begin
      stateNxt = oValorEstado;
    end else begin
      if (iMode != MODE_PING) begin
        dirNxt = DIR_UP;
      end else begin
        dirNxt = dirR;
      end
      if (expire) begin
        case (iMode)
          MODE_LOOP_UP: begin
            if (oValorEstado == LAST) begin
              stateNxt = STATE_W'(0);
              wrapNxt  = 1'b1;
            end else begin
              stateNxt = oValorEstado + STATE_W'(1);
            end
          end
          MODE_LOOP_DN: begin
            if (oValorEstado == STATE_W'(0)) begin
              stateNxt = LAST;
              wrapNxt  = 1'b1;
            end else begin
              stateNxt = oValorEstado - STATE_W'(1);
            end
          end
          MODE_PING: begin
            // Turn around at either end without repeating the endpoint.
            if (dirR == DIR_UP) begin
              if (oValorEstado == LAST) begin
                stateNxt = (NUM_STATES > 1) ? LAST - STATE_W'(1) : STATE_W'(0);
                dirNxt   = DIR_DN;
              end else begin
                stateNxt = oValorEstado + STATE_W'(1);
                dirNxt   = DIR_UP;
              end
            end else begin
              if (oValorEstado == STATE_W'(0)) begin
                stateNxt = (NUM_STATES > 1) ? STATE_W'(1) : STATE_W'(0);
                dirNxt   = DIR_UP;
              end else begin
                stateNxt = oValorEstado - STATE_W'(1);
                dirNxt   = DIR_DN;
              end
            end
            wrapNxt = (stateNxt == STATE_W'(0));
          end
          MODE_ONESHOT: begin
            if (oValorEstado == LAST) begin
              doneNxt = 1'b1;
            end else begin
              stateNxt = oValorEstado + STATE_W'(1);
            end
          end
          default: begin
            stateNxt = oValorEstado;
          end
        endcase
      end else begin
        stateNxt = oValorEstado;
      end
    end
    oneHotNxt = ONE_HOT0 << stateNxt;
  end

  // Output and direction registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oValorEstado <= STATE_W'(0);
      oOneHot      <= ONE_HOT0;
      oWrap        <= 1'b0;
      oDone        <= 1'b0;
      dirR         <= DIR_UP;
    end else begin
      oValorEstado <= stateNxt;
      oOneHot      <= oneHotNxt;
      oWrap        <= wrapNxt;
      oDone        <= doneNxt;
      dirR         <= dirNxt;
    end
  end

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer over several NUM_STATES / DWELL_W instances.
module tb_state_sequencer;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       restart = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] dwell8 = 8'd1;
  logic [3:0] dwell4 = 4'd15;

  logic [1:0] st3;  logic [2:0] oh3;  logic wr3;  logic dn3;
  logic [1:0] st4;  logic [3:0] oh4;  logic wr4;  logic dn4;
  logic [0:0] stA;  logic [0:0] ohA;  logic wrA;  logic dnA;
  logic [0:0] stB;  logic [1:0] ohB;  logic wrB;  logic dnB;
  logic [2:0] stC;  logic [4:0] ohC;  logic wrC;  logic dnC;

  int checks = 0;
  int errors = 0;

  int seq1 [8] = '{0, 1, 1, 2, 2, 0, 0, 1};
  int wrp1 [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int seqDn [5] = '{3, 2, 1, 0, 3};
  int wrpDn [5] = '{1, 0, 0, 0, 1};
  int seqPp [7] = '{1, 2, 3, 2, 1, 0, 1};
  int wrpPp [7] = '{0, 0, 0, 0, 0, 1, 0};
  int seqOs [8] = '{0, 0, 1, 1, 1, 2, 2, 2};
  int nTab [3] = '{1, 2, 5};
  int mCnt [3];
  int mSt [3];
  int mWr [3];
  int mWrapTot [3];
  int dWrapTot [3];
  int oSt [3];
  int oWr [3];
  int oOh [3];

  always #5 clk = ~clk;

  state_sequencer #(.NUM_STATES(3), .DWELL_W(8)) dut3 (
    .iClk(clk), .iRst_n(rstN), .iRestart(restart), .iPause(pause), .iMode(mode),
    .iDwell(dwell8), .oValorEstado(st3), .oOneHot(oh3), .oWrap(wr3), .oDone(dn3));
  state_sequencer #(.NUM_STATES(4), .DWELL_W(8)) dut4 (
    .iClk(clk), .iRst_n(rstN), .iRestart(restart), .iPause(pause), .iMode(mode),
    .iDwell(dwell8), .oValorEstado(st4), .oOneHot(oh4), .oWrap(wr4), .oDone(dn4));
  state_sequencer #(.NUM_STATES(1), .DWELL_W(4)) dutA (
    .iClk(clk), .iRst_n(rstN), .iRestart(restart), .iPause(pause), .iMode(mode),
    .iDwell(dwell4), .oValorEstado(stA), .oOneHot(ohA), .oWrap(wrA), .oDone(dnA));
  state_sequencer #(.NUM_STATES(2), .DWELL_W(4)) dutB (
    .iClk(clk), .iRst_n(rstN), .iRestart(restart), .iPause(pause), .iMode(mode),
    .iDwell(dwell4), .oValorEstado(stB), .oOneHot(ohB), .oWrap(wrB), .oDone(dnB));
  state_sequencer #(.NUM_STATES(5), .DWELL_W(4)) dutC (
    .iClk(clk), .iRst_n(rstN), .iRestart(restart), .iPause(pause), .iMode(mode),
    .iDwell(dwell4), .oValorEstado(stC), .oOneHot(ohC), .oWrap(wrC), .oDone(dnC));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset, checked before any release.
    #2 rstN = 1'b0;
    #10;
    check("rst_state", 32'(st3), 32'd0);
    check("rst_onehot", 32'(oh3), 32'd1);
    check("rst_wrap", 32'(wr3), 32'd0);
    check("rst_done", 32'(dn3), 32'd0);
    rstN = 1'b1;

    // Loop up, N=3, dwell 1.
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("lu_state[%0d]", i), 32'(st3), 32'(seq1[i]));
      check($sformatf("lu_wrap[%0d]", i), 32'(wr3), 32'(wrp1[i]));
      check($sformatf("lu_onehot[%0d]", i), 32'(oh3), 32'(1 << seq1[i]));
    end

    // Loop down, N=4, dwell 0.
    mode = 2'b01; dwell8 = 8'd0; restart = 1'b1;
    step();
    restart = 1'b0;
    check("ld_start", 32'(st4), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("ld_state[%0d]", i), 32'(st4), 32'(seqDn[i]));
      check($sformatf("ld_wrap[%0d]", i), 32'(wr4), 32'(wrpDn[i]));
      check($sformatf("ld_onehot[%0d]", i), 32'(oh4), 32'(1 << seqDn[i]));
    end

    // Ping-pong, N=4, dwell 0.
    mode = 2'b10; restart = 1'b1;
    step();
    restart = 1'b0;
    check("pp_start", 32'(st4), 32'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("pp_state[%0d]", i), 32'(st4), 32'(seqPp[i]));
      check($sformatf("pp_wrap[%0d]", i), 32'(wr4), 32'(wrpPp[i]));
    end
    check("pp_done", 32'(dn4), 32'd0);

    // One-shot, N=3, dwell 2; mode change while done must not matter.
    mode = 2'b11; dwell8 = 8'd2; restart = 1'b1;
    step();
    restart = 1'b0;
    check("os_start", 32'(st3), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("os_state[%0d]", i), 32'(st3), 32'(seqOs[i]));
      check($sformatf("os_done[%0d]", i), 32'(dn3), 32'd0);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 10) mode = 2'b00;
      step();
      check($sformatf("os_hold_state[%0d]", i), 32'(st3), 32'd2);
      check($sformatf("os_hold_done[%0d]", i), 32'(dn3), 32'd1);
      check($sformatf("os_hold_wrap[%0d]", i), 32'(wr3), 32'd0);
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("os_restart_state", 32'(st3), 32'd0);
    check("os_restart_done", 32'(dn3), 32'd0);

    // Pause mid-dwell (loop up, dwell 3): count resumes where it stopped.
    mode = 2'b00; dwell8 = 8'd3; restart = 1'b1;
    step();
    restart = 1'b0;
    step(); step();
    check("pz_before", 32'(st3), 32'd0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("pz_state[%0d]", i), 32'(st3), 32'd0);
      check($sformatf("pz_wrap[%0d]", i), 32'(wr3), 32'd0);
    end
    pause = 1'b0;
    step();
    check("pz_resume1", 32'(st3), 32'd0);
    step();
    check("pz_resume2", 32'(st3), 32'd1);
    pause = 1'b1; restart = 1'b1;
    step();
    pause = 1'b0; restart = 1'b0;
    check("pz_rst_state", 32'(st3), 32'd0);
    check("pz_rst_onehot", 32'(oh3), 32'd1);

    // Async reset while at state 2 with done set.
    mode = 2'b11; dwell8 = 8'd0; restart = 1'b1;
    step();
    restart = 1'b0;
    step(); step(); step();
    check("ar_pre_state", 32'(st3), 32'd2);
    check("ar_pre_done", 32'(dn3), 32'd1);
    #3 rstN = 1'b0;
    #1;
    check("ar_state", 32'(st3), 32'd0);
    check("ar_onehot", 32'(oh3), 32'd1);
    check("ar_wrap", 32'(wr3), 32'd0);
    check("ar_done", 32'(dn3), 32'd0);
    #2 rstN = 1'b1;
    mode = 2'b00; dwell8 = 8'd1;
    step();
    check("ar_release1", 32'(st3), 32'd0);
    step();
    check("ar_release2", 32'(st3), 32'd1);

    // Sweep N=1,2,5 at DWELL_W=4, iDwell=15 with random pause against a model.
    mode = 2'b00; dwell4 = 4'd15; restart = 1'b1;
    step();
    restart = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mCnt[k] = 0; mSt[k] = 0; mWr[k] = 0; mWrapTot[k] = 0; dWrapTot[k] = 0;
    end
    check("sw_start", 32'(stC), 32'd0);
    for (int c = 0; c < 1000; c++) begin
      pause = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      step();
      oSt[0] = int'(stA); oSt[1] = int'(stB); oSt[2] = int'(stC);
      oWr[0] = int'(wrA); oWr[1] = int'(wrB); oWr[2] = int'(wrC);
      oOh[0] = int'(ohA); oOh[1] = int'(ohB); oOh[2] = int'(ohC);
      for (int k = 0; k < 3; k++) begin
        mWr[k] = 0;
        if (!pause) begin
          if (mCnt[k] == 15) begin
            mCnt[k] = 0;
            mSt[k] = (mSt[k] + 1) % nTab[k];
            if (mSt[k] == 0) mWr[k] = 1;
          end else begin
            mCnt[k] = mCnt[k] + 1;
          end
        end
        mWrapTot[k] += mWr[k];
        dWrapTot[k] += oWr[k];
        check($sformatf("sw_state_n%0d[%0d]", nTab[k], c), 32'(oSt[k]), 32'(mSt[k]));
        check($sformatf("sw_wrap_n%0d[%0d]", nTab[k], c), 32'(oWr[k]), 32'(mWr[k]));
        check($sformatf("sw_onehot_n%0d[%0d]", nTab[k], c), 32'(oOh[k]), 32'(1 << mSt[k]));
      end
    end
    pause = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sw_wraptotal_n%0d", nTab[k]), 32'(dWrapTot[k]), 32'(mWrapTot[k]));
    end
    check("sw_doneA", 32'(dnA), 32'd0);
    check("sw_doneB", 32'(dnB), 32'd0);
    check("sw_doneC", 32'(dnC), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
Name: state_sequencer

Overview:
- Parametrised successor of the team's fixed 3-state restart/pause sequencer.
- Cycles through NUM_STATES states, holding each for a programmable dwell time.
- Four traversal modes: loop up, loop down, ping-pong, one-shot.
- Exports the state index, a one-hot decode, a wrap pulse and a done flag to downstream datapath/display logic.

Parameters:
- NUM_STATES, 3, number of states (1..256).
- STATE_W, $clog2(NUM_STATES) with a minimum of 1, width of the state index.
- DWELL_W, 8, width of the dwell counter and the iDwell input.

Ports:
- iClk  in  1  system clock, rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iRestart  in  1  synchronous restart to state 0.
- iPause  in  1  freeze all sequencing.
- iMode  in  2  00 loop up, 01 loop down, 10 ping-pong, 11 one-shot up.
- iDwell  in  DWELL_W  each state lasts iDwell+1 cycles.
- oValorEstado  out  STATE_W  current state index (registered).
- oOneHot  out  NUM_STATES  registered one-hot decode of oValorEstado.
- oWrap  out  1  one-cycle pulse on sequence wrap.
- oDone  out  1  sticky, one-shot mode finished.

Behaviour:
Reset and priority:
- iRst_n low, asynchronously: oValorEstado=0, oOneHot=1 (bit0), oWrap=0, oDone=0, dwell counter=0, direction=up.
- Priority order: iRst_n > iRestart > iPause > normal advance.

Restart and pause:
- iRestart high at an edge: next cycle oValorEstado=0, counter=0, oDone=0, direction=up, oWrap=0.
- iPause high (no restart): the state, counter, direction and oDone hold; oWrap=0.

Dwell and advance:
- Dwell counter increments each unpaused cycle.
- When the counter equals iDwell, the counter clears to 0 and the state advances on that same edge.
- A state therefore lasts exactly iDwell+1 unpaused cycles.
- iDwell=0 advances every cycle.
- iDwell is sampled live. If it is lowered below the current count, the counter reaches max and wraps naturally (modulo 2^DWELL_W) before the advance; it is not forced.

Advance by mode (iMode is sampled at the advance edge):
- 00 loop up: N-1 -> 0; oWrap=1 in the cycle after the advance that lands on 0.
- 01 loop down: 0 -> N-1; oWrap pulses on landing at N-1.
- 10 ping-pong: the direction register flips at 0 and at N-1, giving 0,1,..,N-1,N-2,..,1,0,1..
  - oWrap pulses on landing at 0.
  - Endpoints are not repeated.
  - Direction is forced to up whenever iMode!=10.
- 11 one-shot: counts up. At state N-1, a dwell expiry sets oDone=1; the state holds at N-1 and the counter stops.
  - oDone is cleared only by reset or iRestart.
  - Changing mode while oDone=1 has no effect until restart.

Edge cases:
- Mode change mid-dwell: the counter is unaffected; the new mode applies at the next advance.
- Loop down entered at state 0: the next advance goes to N-1 with a wrap pulse.
- NUM_STATES=1:
  - The state is always 0.
  - Loop and ping-pong modes pulse oWrap each dwell expiry.
  - One-shot sets oDone after the first dwell.
- NUM_STATES=2 ping-pong: 0,1,0,1 with oWrap on each return to 0.
- oWrap is never high in two consecutive cycles unless iDwell=0.
- oOneHot always equals 1<<oValorEstado; it is registered on the same edge.
- Reset mid-dwell or mid-pause takes effect immediately (asynchronous). The first advance after reset release happens iDwell+1 cycles later.

Decomposition:
- Package seq_pkg:
  - mode localparams MODE_LOOP_UP=2'b00, MODE_LOOP_DN=2'b01, MODE_PING=2'b10, MODE_ONESHOT=2'b11
  - direction encoding DIR_UP=1'b0, DIR_DN=1'b1
- Sub-module dwell_timer (params DWELL_W):
  - inputs iClk, iRst_n, iClear, iEnable, iDwell
  - output oExpire, which is combinational (counter==iDwell) && iEnable
- The top level holds the state, direction, done and wrap registers plus the next-state logic.

Test Plan:
- Loop up, N=3, iDwell=1, no pause:
  - states 0,0,1,1,2,2,0,0 on consecutive cycles;
  - oWrap high for exactly one cycle when 0 is re-entered;
  - oOneHot 001,010,100.
- Loop down and ping-pong, N=4, iDwell=0:
  - loop down gives 0,3,2,1,0,3;
  - ping-pong gives 0,1,2,3,2,1,0,1 with oWrap on each return to 0.
- One-shot, N=3, iDwell=2:
  - states 0x3, 1x3, 2x3 cycles, then oDone=1 with the state held at 2 for 20 cycles;
  - iRestart pulse -> next cycle state=0, oDone=0.
- Pause/restart priority:
  - mid-dwell, iPause for 5 cycles -> state and counter frozen; resuming completes the remaining dwell;
  - iPause and iRestart together -> state 0 next cycle.
- Async reset: drop iRst_n between clock edges while at state 2 -> outputs go to 0 / 001 / 0 / 0 immediately, without waiting for a clock edge.
- Parameter sweep: N=1, 2, 5 and DWELL_W=4 at iDwell=15 -> the per-state cycle count equals iDwell+1 and oWrap counts match the scoreboard model over 1000 random cycles with random pause.
